decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage with a valid/ready handshake on both sides. It sits between the fetch stage and the execute stage.
- Full decode per instruction: control_t (opcode-level fields), final ALU op from funct3/funct7, register indices, sign-extended immediate and an illegal-instruction flag.
- A 2-entry skid buffer keeps in_ready registered. Optional M-extension decode is enabled by parameter.

Parameters:
- XLEN, 32, datapath width for pc and immediate outputs; must be ≥ 32.
- EN_M, 0, 1 = decode OP funct7=0000001 as MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 = those encodings are illegal.
- EN_SKID, 1, 1 = 2-entry skid buffer; 0 = single register with in_ready = out_ready | ~out_valid (combinational path).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  kill all held entries; also drops this cycle's input.
- in_valid  in  1  fetch holds a valid instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction pc.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  execute consumes this cycle.
- out_ctrl  out  control_t  reg_write, alu_src, alu_op, mem_read, mem_write, mem_to_reg, branch, jump.
- out_rs1, out_rs2, out_rd  out  5 each  register indices; forced to 0 when the format has no such field.
- out_funct3  out  3  passed through for branch/load/store width.
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J by opcode); 0 for R-type.
- out_pc  out  XLEN  pc of the entry.
- out_illegal  out  1  entry is an illegal instruction.

Behaviour:
- Reset (async assert): both entry valids = 0, out_valid = 0, in_ready = 1, all data outputs = 0. Release is synchronous to clk.
- Latency: an instruction accepted at edge N is presented at out_* after edge N; one-cycle latency.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Entries: main (M) drives out_*. Skid (S) is used only when M is held and a new input arrives.
- in_ready = ~S_valid, registered.
- Per edge, in priority order:
  - flush: M_valid = S_valid = 0; input ignored.
  - output transfer with S_valid: M ← S; S ← input if an input transfer occurs, else S_valid = 0.
  - output transfer without S_valid: M ← input if an input transfer occurs, else M_valid = 0.
  - no output transfer and M_valid: input transfer goes to S.
  - no output transfer and ~M_valid: input transfer goes to M.
- Stability: out_* stay stable while out_valid & ~out_ready. No entry is ever lost or duplicated.
- Decode is combinational on in_instr before capture; only decoded fields are stored.
- Opcode-level ctrl:
  - OP: reg_write.
  - OP_IMM: reg_write, alu_src.
  - LOAD: reg_write, mem_read, mem_to_reg, alu_src, ADD.
  - STORE: mem_write, alu_src, ADD.
  - BRANCH: branch, alu_op SUB.
  - JAL/JALR: jump, reg_write.
  - LUI: reg_write, alu_src, COPY_B.
  - AUIPC: reg_write, alu_src, ADD.
- ALU op for OP/OP_IMM comes from funct3 plus funct7[5] (SUB, SRA).
- OP_IMM shifts: funct7 must be 0000000, or 0100000 for SRAI; else illegal.
- Illegal when any of:
  - unknown opcode;
  - instr[1:0] ≠ 2'b11;
  - OP with funct7 not in {0000000, 0100000 (ADD/SRL only)};
  - M-encoding with EN_M = 0;
  - invalid funct3 for LOAD/STORE/BRANCH/JALR.
- Illegal entries still flow through the stage: ctrl = '0, out_illegal = 1, pc kept. Execute raises the trap.
- Immediates: sign bit is instr[31], extended to XLEN. B and J immediates have LSB 0. U immediate = instr[31:12] << 12.
- Reset mid-transfer: entries discarded, no partial outputs.

Decomposition:
- riscv_pkg gains:
  - alu_op enum extended with SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND and the M ops;
  - imm_fmt_t enum (I, S, B, U, J, NONE);
  - decoded_t struct (ctrl, rs1, rs2, rd, funct3, imm, pc, illegal);
  - the opcode constants.
- One sub-module, instr_decode: purely combinational, in_instr/in_pc → decoded_t, parametrised by XLEN and EN_M. decode_stage owns only the skid registers and handshake.

Test Plan:
- 0x00500093 (addi x1,x0,5), out_ready = 1 → next cycle out_valid = 1, reg_write = 1, alu_src = 1, alu_op = ADD, rd = 1, rs1 = 0, imm = 5, illegal = 0.
- Back-to-back 0x0080A103 (lw) then 0x0020A223 (sw) with out_ready held 0 for 3 cycles:
  - in_ready drops to 0 after the second accept;
  - the lw entry is held stable (mem_read = 1, imm = 8);
  - after out_ready = 1: lw, then sw (mem_write = 1, imm = 4, rs2 = 2) in order, with no loss.
- 0x40208233 (sub) → alu_op = SUB; 0x123451B7 (lui x3) → imm = 0x12345000, alu_op = COPY_B.
- 0x022082B3 (mul): EN_M = 0 → illegal = 1, ctrl = '0; EN_M = 1 → alu_op = MUL, illegal = 0. Also 0x00000000 → illegal = 1.
- Both entries full, flush = 1 with in_valid = 1 → next cycle out_valid = 0, in_ready = 1; the flushed input never appears.
- rst asserted asynchronously between clock edges while entries are held → out_valid = 0 immediately; after release, 0xFFF00093 (addi x1,x0,-1) decodes with imm = 0xFFFFFFFF.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, ALU operations, immediate formats and
// the decoded-instruction record that flows from decode into execute.
// Immediate and pc fields are held at XLEN_MAX bits; users slice to their XLEN.
package riscv_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_COPY_B,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_t;

    typedef enum logic [2:0] { IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE } imm_fmt_t;

    typedef struct packed {
        logic    reg_write;
        logic    alu_src;
        alu_op_t alu_op;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch;
        logic    jump;
    } control_t;

    typedef struct packed {
        control_t              ctrl;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [2:0]            funct3;
        logic [XLEN_MAX-1:0]   imm;
        logic [XLEN_MAX-1:0]   pc;
        logic                  illegal;
    } decoded_t;

    // Sign-extended immediate; B/J carry an implicit zero LSB.
    function automatic logic [XLEN_MAX-1:0] imm_extract(input logic [31:0] i, input imm_fmt_t fmt);
        case (fmt)
            IMM_I:   return {{52{i[31]}}, i[31:20]};
            IMM_S:   return {{52{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {{32{i[31]}}, i[31:12], 12'b0};
            IMM_J:   return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

    // alt selects SUB/SRA (funct7[5]) for the two funct3 codes that have a variant.
    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_t mul_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational RV32I(+M) decoder: instruction word and pc -> decoded_t.
// Ports: instr (32b word), pc (XLEN), dec (decoded record, zero except pc/illegal when illegal).
// No state, no handshake; latency zero.
module instr_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int EN_M = 0
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output decoded_t        dec
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    control_t   ctrl;
    imm_fmt_t   fmt;
    logic       use_rs1, use_rs2, use_rd, illegal;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        ctrl    = '0;
        fmt     = IMM_NONE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                ctrl.reg_write = 1'b1;
                if (f7 == 7'b0000000)
                    ctrl.alu_op = alu_from_f3(f3, 1'b0);
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    ctrl.alu_op = alu_from_f3(f3, 1'b1);
                else if (f7 == 7'b0000001 && EN_M != 0)
                    ctrl.alu_op = mul_from_f3(f3);
                else
                    illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1; use_rd = 1'b1; fmt = IMM_I;
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
                // Only shifts reinterpret imm[11:5] as funct7.
                case (f3)
                    3'b001: begin
                        ctrl.alu_op = ALU_SLL;
                        if (f7 != 7'b0000000) illegal = 1'b1;
                    end
                    3'b101: begin
                        if (f7 == 7'b0000000)      ctrl.alu_op = ALU_SRL;
                        else if (f7 == 7'b0100000) ctrl.alu_op = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                    default: ctrl.alu_op = alu_from_f3(f3, 1'b0);
                endcase
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1; use_rd = 1'b1; fmt = IMM_I;
                ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) illegal = 1'b1;
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_S;
                ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD;
                if (f3 > 3'b010) illegal = 1'b1;
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_B;
                ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB;
                if (f3 == 3'b010 || f3 == 3'b011) illegal = 1'b1;
            end
            OPC_JAL: begin
                use_rd = 1'b1; fmt = IMM_J;
                ctrl.jump = 1'b1; ctrl.reg_write = 1'b1;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1; use_rd = 1'b1; fmt = IMM_I;
                ctrl.jump = 1'b1; ctrl.reg_write = 1'b1;
                if (f3 != 3'b000) illegal = 1'b1;
            end
            OPC_LUI: begin
                use_rd = 1'b1; fmt = IMM_U;
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_COPY_B;
            end
            OPC_AUIPC: begin
                use_rd = 1'b1; fmt = IMM_U;
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD;
            end
            default: illegal = 1'b1;
        endcase
        // Compressed/reserved encodings land here even if bits [6:2] look familiar.
        if (instr[1:0] != 2'b11) illegal = 1'b1;
    end

    // Illegal entries carry only pc and the flag so execute can trap cleanly.
    always_comb begin
        dec         = '0;
        dec.pc      = XLEN_MAX'(pc);
        dec.illegal = illegal;
        if (!illegal) begin
            dec.ctrl   = ctrl;
            dec.rs1    = use_rs1 ? instr[19:15] : 5'd0;
            dec.rs2    = use_rs2 ? instr[24:20] : 5'd0;
            dec.rd     = use_rd  ? instr[11:7]  : 5'd0;
            dec.funct3 = f3;
            dec.imm    = imm_extract(instr, fmt);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute with valid/ready on both sides.
// Latency: one cycle (accept at edge N, visible after edge N). Ports: clk, rst, flush,
// in_valid/in_ready/in_instr/in_pc upstream, out_valid/out_ready/out_* decoded fields downstream.
// Backpressure: main + skid entry; in_ready = ~skid_valid (registered). With EN_SKID=0 a single
// entry is used and in_ready = out_ready | ~out_valid (combinational).
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int EN_M    = 0,
    parameter int EN_SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output control_t        out_ctrl,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    localparam bit USE_SKID = (EN_SKID != 0);

    decoded_t dec, m_q, s_q;
    logic     m_valid, s_valid;
    logic     in_fire, out_fire;

    instr_decode #(.XLEN(XLEN), .EN_M(EN_M)) u_decode (
        .instr (in_instr),
        .pc    (in_pc),
        .dec   (dec)
    );

    assign in_ready = USE_SKID ? ~s_valid : (out_ready | ~m_valid);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (out_fire && s_valid) begin
            m_q <= s_q;
            if (in_fire) s_q <= dec;
            else         s_valid <= 1'b0;
        end else if (out_fire) begin
            if (in_fire) m_q <= dec;
            m_valid <= in_fire;
        end else if (m_valid) begin
            // Main is stalled: park the newcomer so in_ready can stay registered.
            if (in_fire && USE_SKID) begin
                s_q     <= dec;
                s_valid <= 1'b1;
            end
        end else if (in_fire) begin
            m_q     <= dec;
            m_valid <= 1'b1;
        end
    end

    assign out_valid   = m_valid;
    assign out_ctrl    = m_q.ctrl;
    assign out_rs1     = m_q.rs1;
    assign out_rs2     = m_q.rs2;
    assign out_rd      = m_q.rd;
    assign out_funct3  = m_q.funct3;
    assign out_imm     = m_q.imm[XLEN-1:0];
    assign out_pc      = m_q.pc[XLEN-1:0];
    assign out_illegal = m_q.illegal;

    // Bits above XLEN in the stored record are never driven out.
    logic unused_upper;
    assign unused_upper = ^{m_q.imm, m_q.pc};

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;

    logic        in_ready, out_valid, out_illegal;
    control_t    out_ctrl;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3;
    logic [31:0] out_imm, out_pc;

    logic        m_in_ready, m_out_valid, m_out_illegal;
    control_t    m_out_ctrl;
    logic [4:0]  m_out_rs1, m_out_rs2, m_out_rd;
    logic [2:0]  m_out_funct3;
    logic [31:0] m_out_imm, m_out_pc;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .EN_M(0), .EN_SKID(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(32), .EN_M(1), .EN_SKID(1)) u_dut_m (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_ctrl(m_out_ctrl),
        .out_rs1(m_out_rs1), .out_rs2(m_out_rs2), .out_rd(m_out_rd), .out_funct3(m_out_funct3),
        .out_imm(m_out_imm), .out_pc(m_out_pc), .out_illegal(m_out_illegal)
    );

    typedef struct packed {
        logic [31:0] instr;
        control_t    ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    function automatic control_t mk(input logic rw, input logic src, input alu_op_t op,
                                    input logic mr, input logic mw, input logic m2r,
                                    input logic br, input logic jmp);
        control_t c;
        c.reg_write = rw;  c.alu_src = src;   c.alu_op = op;
        c.mem_read  = mr;  c.mem_write = mw;  c.mem_to_reg = m2r;
        c.branch    = br;  c.jump = jmp;
        return c;
    endfunction

    function automatic vec_t mv(input logic [31:0] i, input control_t c, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] rd, input logic [2:0] f3,
                                input logic [31:0] imm, input logic ill);
        vec_t v;
        v.instr = i; v.ctrl = c; v.rs1 = r1; v.rs2 = r2; v.rd = rd;
        v.f3 = f3; v.imm = imm; v.ill = ill;
        return v;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_dec(input string name, input logic v, input control_t c,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                             input logic [2:0] f3, input logic [31:0] imm, input logic [31:0] pc,
                             input logic ill, input vec_t e, input logic [31:0] epc);
        n_vec++;
        if (v !== 1'b1 || c !== e.ctrl || r1 !== e.rs1 || r2 !== e.rs2 || rd !== e.rd ||
            f3 !== e.f3 || imm !== e.imm || pc !== epc || ill !== e.ill) begin
            n_miss++;
            $display("FAIL %s: got v=%b ctrl=%h rs1=%0d rs2=%0d rd=%0d f3=%0d imm=%h pc=%h ill=%b want v=1 ctrl=%h rs1=%0d rs2=%0d rd=%0d f3=%0d imm=%h pc=%h ill=%b",
                     name, v, c, r1, r2, rd, f3, imm, pc, ill,
                     e.ctrl, e.rs1, e.rs2, e.rd, e.f3, e.imm, epc, e.ill);
        end
    endtask

    task automatic check_main(input string name, input vec_t e, input logic [31:0] epc);
        check_dec(name, out_valid, out_ctrl, out_rs1, out_rs2, out_rd, out_funct3,
                  out_imm, out_pc, out_illegal, e, epc);
    endtask

    task automatic check_m(input string name, input vec_t e, input logic [31:0] epc);
        check_dec(name, m_out_valid, m_out_ctrl, m_out_rs1, m_out_rs2, m_out_rd, m_out_funct3,
                  m_out_imm, m_out_pc, m_out_illegal, e, epc);
    endtask

    initial begin
        control_t c0;
        vec_t     ill_v;
        c0 = mk(0, 0, ALU_ADD, 0, 0, 0, 0, 0);
        vecs[0]  = mv(32'h00500093, mk(1, 1, ALU_ADD,    0, 0, 0, 0, 0), 0, 0, 1, 0, 32'h5, 0);
        vecs[1]  = mv(32'h0080A103, mk(1, 1, ALU_ADD,    1, 0, 1, 0, 0), 1, 0, 2, 2, 32'h8, 0);
        vecs[2]  = mv(32'h0020A223, mk(0, 1, ALU_ADD,    0, 1, 0, 0, 0), 1, 2, 0, 2, 32'h4, 0);
        vecs[3]  = mv(32'h40208233, mk(1, 0, ALU_SUB,    0, 0, 0, 0, 0), 1, 2, 4, 0, 32'h0, 0);
        vecs[4]  = mv(32'h123451B7, mk(1, 1, ALU_COPY_B, 0, 0, 0, 0, 0), 0, 0, 3, 5, 32'h12345000, 0);
        vecs[5]  = mv(32'h022082B3, c0, 0, 0, 0, 0, 32'h0, 1);
        vecs[6]  = mv(32'h00000000, c0, 0, 0, 0, 0, 32'h0, 1);
        vecs[7]  = mv(32'h008000EF, mk(1, 0, ALU_ADD,    0, 0, 0, 0, 1), 0, 0, 1, 0, 32'h8, 0);
        vecs[8]  = mv(32'hFE000EE3, mk(0, 0, ALU_SUB,    0, 0, 0, 1, 0), 0, 0, 0, 0, 32'hFFFFFFFC, 0);
        vecs[9]  = mv(32'h00002063, c0, 0, 0, 0, 0, 32'h0, 1);
        vecs[10] = mv(32'h40335293, mk(1, 1, ALU_SRA,    0, 0, 0, 0, 0), 6, 0, 5, 5, 32'h403, 0);
        vecs[11] = mv(32'h20335293, c0, 0, 0, 0, 0, 32'h0, 1);
        vecs[12] = mv(32'h00500092, c0, 0, 0, 0, 0, 32'h0, 1);
        vecs[13] = mv(32'h00001117, mk(1, 1, ALU_ADD,    0, 0, 0, 0, 0), 0, 0, 2, 1, 32'h1000, 0);
        vecs[14] = mv(32'h00008067, mk(1, 0, ALU_ADD,    0, 0, 0, 0, 1), 1, 0, 0, 0, 32'h0, 0);
        vecs[15] = mv(32'hFFF1F113, mk(1, 1, ALU_AND,    0, 0, 0, 0, 0), 3, 0, 2, 7, 32'hFFFFFFFF, 0);

        // Reset state.
        repeat (2) @(negedge clk);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check32("rst_ctrl", 32'(out_ctrl), 32'h0);
        check32("rst_imm", out_imm, 32'h0);
        check32("rst_pc", out_pc, 32'h0);
        check_bit("rst_illegal", out_illegal, 1'b0);
        rst = 1'b0;

        // Streaming vector table with out_ready held high.
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc    = 32'h1000 + 32'(i * 4);
            @(negedge clk);
            check_main($sformatf("vec%0d", i), vecs[i], 32'h1000 + 32'(i * 4));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_bit("drain_empty", out_valid, 1'b0);

        // lw then sw under 3 cycles of backpressure.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = vecs[1].instr; in_pc = 32'h200;
        @(negedge clk);
        check_bit("bp_rdy_one", in_ready, 1'b1);
        check_main("bp_lw0", vecs[1], 32'h200);
        in_instr = vecs[2].instr; in_pc = 32'h204;
        @(negedge clk);
        in_valid = 1'b0;
        check_bit("bp_rdy_full", in_ready, 1'b0);
        check_main("bp_lw1", vecs[1], 32'h200);
        @(negedge clk);
        check_main("bp_lw2", vecs[1], 32'h200);
        out_ready = 1'b1;
        @(negedge clk);
        check_main("bp_sw", vecs[2], 32'h204);
        check_bit("bp_rdy_back", in_ready, 1'b1);
        @(negedge clk);
        check_bit("bp_empty", out_valid, 1'b0);

        // M-extension encodings on both parameterisations.
        ill_v = mv(32'h0, c0, 0, 0, 0, 0, 32'h0, 1);
        in_valid = 1'b1; in_instr = 32'h022082B3; in_pc = 32'h300;
        @(negedge clk);
        check_main("mul_off", vecs[5], 32'h300);
        check_m("mul_on", mv(32'h0, mk(1, 0, ALU_MUL, 0, 0, 0, 0, 0), 1, 2, 5, 0, 32'h0, 0), 32'h300);
        in_instr = 32'h0220B2B3; in_pc = 32'h304;
        @(negedge clk);
        check_main("mulhu_off", ill_v, 32'h304);
        check_m("mulhu_on", mv(32'h0, mk(1, 0, ALU_MULHU, 0, 0, 0, 0, 0), 1, 2, 5, 3, 32'h0, 0), 32'h304);
        in_instr = 32'h0220D2B3; in_pc = 32'h308;
        @(negedge clk);
        check_m("divu_on", mv(32'h0, mk(1, 0, ALU_DIVU, 0, 0, 0, 0, 0), 1, 2, 5, 5, 32'h0, 0), 32'h308);
        in_valid = 1'b0;
        @(negedge clk);

        // Flush with both entries full and an input offered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = vecs[0].instr; in_pc = 32'h400;
        @(negedge clk);
        in_instr = vecs[3].instr; in_pc = 32'h404;
        @(negedge clk);
        check_bit("fl_full_rdy", in_ready, 1'b0);
        in_instr = vecs[4].instr; in_pc = 32'h408; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check_bit("fl_out_valid", out_valid, 1'b0);
        check_bit("fl_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_bit("fl_no_ghost", out_valid, 1'b0);

        // Flush while input would have been accepted into the skid entry.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = vecs[0].instr; in_pc = 32'h410;
        @(negedge clk);
        check_bit("fl2_rdy", in_ready, 1'b1);
        in_instr = vecs[4].instr; in_pc = 32'h414; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check_bit("fl2_empty", out_valid, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        check_bit("fl2_no_input", out_valid, 1'b0);

        // Asynchronous reset between edges with both entries held.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = vecs[0].instr; in_pc = 32'h500;
        @(negedge clk);
        in_instr = vecs[3].instr; in_pc = 32'h504;
        @(negedge clk);
        in_valid = 1'b0;
        check_bit("ar_held", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_bit("ar_out_valid", out_valid, 1'b0);
        check_bit("ar_in_ready", in_ready, 1'b1);
        check32("ar_pc", out_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h600;
        @(negedge clk);
        in_valid = 1'b0;
        check_main("ar_addi_neg1",
                   mv(32'h0, mk(1, 1, ALU_ADD, 0, 0, 0, 0, 0), 0, 0, 1, 0, 32'hFFFFFFFF, 0), 32'h600);
        @(negedge clk);
        check_bit("ar_no_stale", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
